// File: rtl/pipe_tx_lane_buffer_if.sv
// ----------------------------------------------------------------------------
// pipe_tx_lane_buffer_if
//
// Purpose:
//   Bundles the write (decoder side) and read (encoder side) signals of the
//   TX lane elastic buffer, together with its status flags.
//
// Signals:
//   wr_en, wr_data, wr_byte_valid, wr_sel : write word, byte mask, path select
//   rd_en                                  : pop the head entry
//   rd_valid, rd_data, rd_byte_valid,
//   rd_sel                                 : FWFT head entry (zeroed when empty)
//   full, count                            : occupancy status
//   overflow, underflow                    : sticky error flags
//
// Modports:
//   master : upstream/downstream logic that drives the buffer
//   slave  : the buffer itself
// ----------------------------------------------------------------------------
interface pipe_tx_lane_buffer_if #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [63:0]           wr_byte_valid;
    logic                  wr_sel;
    logic                  rd_en;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [63:0]           rd_byte_valid;
    logic                  rd_sel;
    logic                  full;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, wr_data, wr_byte_valid, wr_sel, rd_en,
        input  rd_valid, rd_data, rd_byte_valid, rd_sel,
        input  full, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, wr_byte_valid, wr_sel, rd_en,
        output rd_valid, rd_data, rd_byte_valid, rd_sel,
        output full, count, overflow, underflow
    );
endinterface

// File: rtl/pipe_tx_lane_buffer.sv
// ----------------------------------------------------------------------------
// pipe_tx_lane_buffer
//
// Purpose:
//   Write-side elastic buffer between the generation/lane decoder and the
//   per-lane encoders. Each accepted write stores one TX word, its 64-bit
//   byte-valid mask and its encoder-path select (0 = 8b/10b, 1 = 128b/130b).
//   The oldest entry is presented first-word-fall-through; bytes whose mask
//   bit is 0 are forced to 8'h00 so the encoders never see stale data.
//
// Ports:
//   clk       in   single clock, rising edge
//   reset     in   synchronous, active-high
//   bus       slave modport of pipe_tx_lane_buffer_if (write/read/status)
//   drop_cnt  out  [7:0] saturating count of dropped writes
//                  (only when PIPE_TX_LANE_BUF_DROP_CNT_EN is defined)
//
// Configuration:
//   PIPE_TX_LANE_BUF_DROP_CNT_EN - when defined, adds the drop_cnt port and
//   its counter. When undefined, neither exists; all else is identical.
//
// Notes:
//   - A write with an all-zero mask is a no-op (not stored, never an overflow).
//   - When full, a write is still accepted if the head is popped in the same
//     cycle; occupancy then stays at DEPTH.
//   - A read on an empty buffer is ignored even if a write lands in the same
//     cycle; there is no bypass into an empty buffer.
// ----------------------------------------------------------------------------
module pipe_tx_lane_buffer #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    pipe_tx_lane_buffer_if.slave     bus
`ifdef PIPE_TX_LANE_BUF_DROP_CNT_EN
    ,
    output logic [7:0]               drop_cnt
`endif
);

    localparam int NBYTES = 64;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef struct packed {
        logic                  sel;
        logic [NBYTES-1:0]     mask;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    entry_t              r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_overflow;
    logic                r_underflow;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic                w_empty;
    logic                w_full;
    logic                w_wr_req;
    logic                w_rd_acc;
    logic                w_wr_acc;
    logic                w_wr_drop;
    logic                w_rd_empty;
    entry_t              w_head;
    logic [DATA_WIDTH-1:0] w_byte_en;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(DEPTH));

    // A zero mask carries no payload, so it never counts as a write request.
    assign w_wr_req   = bus.wr_en & (|bus.wr_byte_valid);
    assign w_rd_acc   = bus.rd_en & ~w_empty;
    // A pop in the same cycle frees the slot the write needs when full.
    assign w_wr_acc   = w_wr_req & (~w_full | w_rd_acc);
    assign w_wr_drop  = w_wr_req & w_full & ~w_rd_acc;
    assign w_rd_empty = bus.rd_en & w_empty;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // NOTE: the entry array has no reset; validity is tracked by the
    // pointers and count, so clearing it would only cost flops and fanout.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= '{sel: bus.wr_sel, mask: bus.wr_byte_valid, data: bus.wr_data};
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and sticky flags
    // ------------------------------------------------------------------
    // NOTE: all state updates use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            // Power-of-two depth: pointer wrap DEPTH-1 -> 0 is the natural rollover.
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end

            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (w_wr_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_rd_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifdef PIPE_TX_LANE_BUF_DROP_CNT_EN
    // ------------------------------------------------------------------
    // Dropped-write counter, saturating at 8'hFF
    // ------------------------------------------------------------------
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (w_wr_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    // ------------------------------------------------------------------
    // FWFT head with byte masking
    // ------------------------------------------------------------------
    assign w_head = r_mem[r_rd_ptr];

    // NOTE: the default assignment before the loop keeps this block free of
    // inferred latches even if the loop bounds are ever changed.
    always_comb begin
        w_byte_en = '0;
        for (int k = 0; k < NBYTES; k++) begin
            w_byte_en[8*k +: 8] = {8{w_head.mask[k]}};
        end
    end

    // Head fields are gated with !empty so uninitialised entries never leak out.
    assign bus.rd_valid      = ~w_empty;
    assign bus.rd_data       = w_empty ? '0 : (w_head.data & w_byte_en);
    assign bus.rd_byte_valid = w_empty ? '0 : w_head.mask;
    assign bus.rd_sel        = w_empty ? 1'b0 : w_head.sel;

    assign bus.full          = w_full;
    assign bus.count         = r_count;
    assign bus.overflow      = r_overflow;
    assign bus.underflow     = r_underflow;

endmodule

// File: tb/tb_pipe_tx_lane_buffer.sv
// ----------------------------------------------------------------------------
// tb_pipe_tx_lane_buffer
//
// Purpose:
//   Self-checking bench for pipe_tx_lane_buffer. A reference model tracks
//   occupancy and sticky flags; each accepted write pushes its expected
//   (masked) head entry into a queue that is compared when the entry pops.
// ----------------------------------------------------------------------------
module tb_pipe_tx_lane_buffer;

    localparam int DATA_WIDTH = 512;
    localparam int DEPTH      = 8;

    typedef struct packed {
        logic                  sel;
        logic [63:0]           mask;
        logic [DATA_WIDTH-1:0] data;
    } exp_t;

    logic clk;
    logic reset;
`ifdef PIPE_TX_LANE_BUF_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    pipe_tx_lane_buffer_if #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) bus ();

    pipe_tx_lane_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus)
`ifdef PIPE_TX_LANE_BUF_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    exp_t sb_q [$];
    int   m_cnt;
    logic m_ovf;
    logic m_udf;
    int   m_drop;

    int   n_tests;
    int   n_fail;

    task automatic check(input string tag, input logic [DATA_WIDTH-1:0] got,
                         input logic [DATA_WIDTH-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_WIDTH-1:0] mask_data(input logic [DATA_WIDTH-1:0] d,
                                                        input logic [63:0] m);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < 64; k++) begin
            if (m[k]) r[8*k +: 8] = d[8*k +: 8];
        end
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rand_word();
        logic [DATA_WIDTH-1:0] r;
        for (int k = 0; k < DATA_WIDTH / 32; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    // Compare every observable output against the model.
    task automatic check_state();
        exp_t e;
        check("count",     512'(bus.count),     512'(m_cnt));
        check("full",      512'(bus.full),      512'(m_cnt == DEPTH));
        check("rd_valid",  512'(bus.rd_valid),  512'(m_cnt != 0));
        check("overflow",  512'(bus.overflow),  512'(m_ovf));
        check("underflow", 512'(bus.underflow), 512'(m_udf));
`ifdef PIPE_TX_LANE_BUF_DROP_CNT_EN
        check("drop_cnt",  512'(drop_cnt),      512'(m_drop));
`endif
        if (sb_q.size() == 0) begin
            check("empty_data", bus.rd_data,             '0);
            check("empty_mask", 512'(bus.rd_byte_valid), '0);
            check("empty_sel",  512'(bus.rd_sel),        '0);
        end else begin
            e = sb_q[0];
            check("head_data", bus.rd_data,             e.data);
            check("head_mask", 512'(bus.rd_byte_valid), 512'(e.mask));
            check("head_sel",  512'(bus.rd_sel),        512'(e.sel));
        end
    endtask

    // One clock of stimulus; model is advanced with the pre-edge view.
    task automatic step(input logic we, input logic [DATA_WIDTH-1:0] wd,
                        input logic [63:0] wm, input logic ws, input logic re);
        exp_t e;
        logic rd_acc_m;
        logic wr_acc_m;
        bus.wr_en         = we;
        bus.wr_data       = wd;
        bus.wr_byte_valid = wm;
        bus.wr_sel        = ws;
        bus.rd_en         = re;
        rd_acc_m = re && (m_cnt > 0);
        if (rd_acc_m) begin
            e = sb_q.pop_front();
            check("pop_data", bus.rd_data,             e.data);
            check("pop_mask", 512'(bus.rd_byte_valid), 512'(e.mask));
            check("pop_sel",  512'(bus.rd_sel),        512'(e.sel));
        end
        wr_acc_m = we && (wm != 64'h0) && ((m_cnt < DEPTH) || rd_acc_m);
        if (wr_acc_m) begin
            e.sel  = ws;
            e.mask = wm;
            e.data = mask_data(wd, wm);
            sb_q.push_back(e);
        end
        if (we && (wm != 64'h0) && !wr_acc_m) begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
        end
        if (re && (m_cnt == 0)) m_udf = 1'b1;
        if (wr_acc_m && !rd_acc_m)      m_cnt++;
        else if (rd_acc_m && !wr_acc_m) m_cnt--;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        check_state();
    endtask

    task automatic do_reset(input logic inflight_wr);
        reset             = 1'b1;
        bus.wr_en         = inflight_wr;
        bus.wr_data       = rand_word();
        bus.wr_byte_valid = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.wr_sel        = 1'b1;
        bus.rd_en         = 1'b0;
        @(posedge clk);
        #1;
        sb_q.delete();
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_drop = 0;
        reset     = 1'b0;
        bus.wr_en = 1'b0;
        check_state();
    endtask

    task automatic idle();
        step(1'b0, '0, 64'h0, 1'b0, 1'b0);
    endtask

    logic [DATA_WIDTH-1:0] a5_word;
    logic [63:0]           rmask;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus.wr_en = 1'b0;
        bus.wr_data = '0;
        bus.wr_byte_valid = '0;
        bus.wr_sel = 1'b0;
        bus.rd_en = 1'b0;
        a5_word = {64{8'hA5}};

        // T1: single masked write, visible one edge later
        do_reset(1'b0);
        step(1'b1, a5_word, 64'h0000_0000_0000_00FF, 1'b0, 1'b0);
        check("t1_lo",    512'(bus.rd_data[63:0]),   512'(64'hA5A5_A5A5_A5A5_A5A5));
        check("t1_hi",    512'(bus.rd_data[511:64]), '0);
        check("t1_count", 512'(bus.count),           512'(1));
        step(1'b0, '0, 64'h0, 1'b0, 1'b1);

        // T2: nine writes into a depth-8 buffer, then drain
        do_reset(1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, rand_word(), 64'hFFFF_FFFF_FFFF_FFFF, i[0], 1'b0);
        check("t2_full", 512'(bus.full),     512'(1));
        check("t2_ovf",  512'(bus.overflow), 512'(1));
`ifdef PIPE_TX_LANE_BUF_DROP_CNT_EN
        check("t2_drop", 512'(drop_cnt),     512'(1));
`endif
        for (int i = 0; i < 8; i++) step(1'b0, '0, 64'h0, 1'b0, 1'b1);
        check("t2_empty", 512'(bus.rd_valid), '0);

        // T3: full with concurrent read and write
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, rand_word(), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, rand_word(), 64'h00FF_0F0F_F0F0_8001, 1'b1, 1'b1);
        check("t3_count", 512'(bus.count),    512'(8));
        check("t3_ovf",   512'(bus.overflow), '0);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 64'h0, 1'b0, 1'b1);

        // T4: zero-mask write is a no-op; read on empty sets underflow
        do_reset(1'b0);
        step(1'b1, rand_word(), 64'h0, 1'b1, 1'b0);
        check("t4_count", 512'(bus.count),    '0);
        check("t4_ovf",   512'(bus.overflow), '0);
        step(1'b0, '0, 64'h0, 1'b0, 1'b1);
        check("t4_udf",   512'(bus.underflow), 512'(1));
        check("t4_data",  bus.rd_data,         '0);
        // empty + write + read in the same cycle: write kept, read ignored
        step(1'b1, rand_word(), 64'h8000_0000_0000_0001, 1'b1, 1'b1);
        check("t4_wr_kept", 512'(bus.count), 512'(1));
        step(1'b0, '0, 64'h0, 1'b0, 1'b1);

        // T5: per-entry sel/mask with pointer wrap past entry 7
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, rand_word(), 64'h1, 1'b0, 1'b0);
            step(1'b0, '0, 64'h0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 3; i++) step(1'b1, rand_word(), 64'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, rand_word(), 64'hFFFF_FFFF, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 64'h0, 1'b0, 1'b1);

        // Mixed random traffic including sparse and zero masks
        do_reset(1'b0);
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       rmask = 64'h0;
                1:       rmask = 64'hFFFF_FFFF_FFFF_FFFF;
                default: rmask = {$urandom, $urandom} & {$urandom, $urandom};
            endcase
            step(1'($urandom_range(0, 1)), rand_word(), rmask,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
        end

        // T6: reset while holding entries and writing
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, rand_word(), 64'hF0F0, 1'b1, 1'b0);
        step(1'b0, '0, 64'h0, 1'b0, 1'b1);
        check("t6_udf_pre", 512'(bus.underflow), '0);
        do_reset(1'b1);
        check("t6_count", 512'(bus.count),         '0);
        check("t6_valid", 512'(bus.rd_valid),      '0);
        check("t6_mask",  512'(bus.rd_byte_valid), '0);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
